// File: rtl/pipeline_control_unit_pkg.sv
// Shared definitions for the pipeline control unit: FSM state encodings,
// default counter width and the MDU counter load-value helper.
package pipeline_control_unit_pkg;

    localparam int PCU_CNT_WIDTH = 8;

    typedef enum logic [1:0] {
        PCU_RUN      = 2'd0,
        PCU_MDU_BUSY = 2'd1,
        PCU_HALT     = 2'd2
    } pcuState_t;

    // Value loaded into the MDU down-counter at issue: the issue cycle and
    // the final (done) cycle are not counted, hence latency minus two.
    function automatic int mduLoadValue(input int latency);
        return (latency > 2) ? (latency - 2) : 0;
    endfunction

endpackage

// File: rtl/pipeline_control_unit_if.sv
// Handshake bundle between the pipeline datapath and the control unit.
// master: the datapath (drives requests, consumes enables/flushes).
// slave : the control unit.
interface pipeline_control_unit_if;
    logic loadUseStall_ID;
    logic redirect_EX;
    logic mduOp_EX;
    logic dmemReq_MEM;
    logic dmemReady;
    logic PCEn;
    logic IFIDEn;
    logic IDEXEn;
    logic EXMEMEn;
    logic MEMWBEn;
    logic IFIDFlush;
    logic IDEXFlush;
    logic EXMEMFlush;
    logic MEMWBFlush;
    logic mduDone;
    logic memFault;

    modport master (
        output loadUseStall_ID, redirect_EX, mduOp_EX, dmemReq_MEM, dmemReady,
        input  PCEn, IFIDEn, IDEXEn, EXMEMEn, MEMWBEn,
        input  IFIDFlush, IDEXFlush, EXMEMFlush, MEMWBFlush, mduDone, memFault
    );

    modport slave (
        input  loadUseStall_ID, redirect_EX, mduOp_EX, dmemReq_MEM, dmemReady,
        output PCEn, IFIDEn, IDEXEn, EXMEMEn, MEMWBEn,
        output IFIDFlush, IDEXFlush, EXMEMFlush, MEMWBFlush, mduDone, memFault
    );
endinterface

// File: rtl/pipeline_control_unit_pcu_down_counter.sv
// Loadable down-counter that saturates at zero, with a zero flag.
// Used to time the remaining cycles of a multi-cycle MUL/DIV op.
module pcu_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] loadValue,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    // Count register: load has priority over decrement; hold at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (dec && (count != '0)) begin
            count <= count - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count <= count;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pipeline_control_unit.sv
// Stall/flush sequencer for the 5-stage pipeline. Merges memory wait,
// multi-cycle MDU, EX redirect and load-use requests into per-stage
// enables and flushes (priority: HALT > memStall > MDU > redirect > load-use).
// Optional memory-timeout HALT is built when PIPE_MEM_TIMEOUT_EN is defined.
module pipeline_control_unit
    import pipeline_control_unit_pkg::*;
#(
    parameter int MDU_LATENCY = 4,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_WIDTH   = PCU_CNT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    pipeline_control_unit_if.slave  pcu
);

    localparam logic                 MDU_MULTI = (MDU_LATENCY > 1);
    localparam logic [CNT_WIDTH-1:0] MDU_LOAD  = CNT_WIDTH'(mduLoadValue(MDU_LATENCY));

    pcuState_t            state;
    pcuState_t            stateNext;
    logic                 memStall;
    logic                 mduIssue;
    logic                 mduDec;
    logic [CNT_WIDTH-1:0] mduCnt;
    logic                 mduZero;
    logic                 timeoutHit;

    assign memStall = pcu.dmemReq_MEM & ~pcu.dmemReady;
    // An MDU op only starts timing once EX is actually allowed to operate.
    assign mduIssue = (state == PCU_RUN) & pcu.mduOp_EX & ~memStall & MDU_MULTI;
    assign mduDec   = (state == PCU_MDU_BUSY);

    pcu_down_counter #(.WIDTH(CNT_WIDTH)) uMduCounter (
        .clk       (clk),
        .rst       (rst),
        .load      (mduIssue),
        .loadValue (MDU_LOAD),
        .dec       (mduDec),
        .count     (mduCnt),
        .zero      (mduZero)
    );

`ifdef PIPE_MEM_TIMEOUT_EN
    logic [CNT_WIDTH-1:0] memWaitCnt;

    // Consecutive memory-wait counter; frozen once halted.
    always_ff @(posedge clk) begin
        if (rst) begin
            memWaitCnt <= '0;
        end else if (state == PCU_HALT) begin
            memWaitCnt <= memWaitCnt;
        end else if (memStall) begin
            memWaitCnt <= memWaitCnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            memWaitCnt <= '0;
        end
    end

    assign timeoutHit = memStall & (state != PCU_HALT) &
                        (memWaitCnt == CNT_WIDTH'(MEM_TIMEOUT - 1));
`else
    assign timeoutHit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PCU_RUN;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic.
    always_comb begin
        stateNext = state;
        case (state)
            PCU_RUN: begin
                if (timeoutHit) begin
                    stateNext = PCU_HALT;
                end else if (mduIssue) begin
                    stateNext = PCU_MDU_BUSY;
                end else begin
                    stateNext = PCU_RUN;
                end
            end
            PCU_MDU_BUSY: begin
                if (timeoutHit) begin
                    stateNext = PCU_HALT;
                end else if (mduZero && !memStall) begin
                    stateNext = PCU_RUN;
                end else begin
                    stateNext = PCU_MDU_BUSY;
                end
            end
            PCU_HALT: begin
                stateNext = PCU_HALT;
            end
            default: begin
                stateNext = PCU_RUN;
            end
        endcase
    end

    // Output decode: start from free-running values, then apply the
    // highest-priority active condition.
    always_comb begin
        pcu.PCEn       = 1'b1;
        pcu.IFIDEn     = 1'b1;
        pcu.IDEXEn     = 1'b1;
        pcu.EXMEMEn    = 1'b1;
        pcu.MEMWBEn    = 1'b1;
        pcu.IFIDFlush  = 1'b0;
        pcu.IDEXFlush  = 1'b0;
        pcu.EXMEMFlush = 1'b0;
        pcu.MEMWBFlush = 1'b0;
        pcu.mduDone    = 1'b0;
        pcu.memFault   = 1'b0;
        if (rst) begin
            pcu.memFault = 1'b0;
        end else if (state == PCU_HALT) begin
            pcu.PCEn     = 1'b0;
            pcu.IFIDEn   = 1'b0;
            pcu.IDEXEn   = 1'b0;
            pcu.EXMEMEn  = 1'b0;
            pcu.MEMWBEn  = 1'b0;
            pcu.memFault = 1'b1;
        end else if (memStall) begin
            pcu.PCEn       = 1'b0;
            pcu.IFIDEn     = 1'b0;
            pcu.IDEXEn     = 1'b0;
            pcu.EXMEMEn    = 1'b0;
            pcu.MEMWBFlush = 1'b1;
        end else if ((state == PCU_MDU_BUSY && !mduZero) || mduIssue) begin
            pcu.PCEn       = 1'b0;
            pcu.IFIDEn     = 1'b0;
            pcu.IDEXEn     = 1'b0;
            pcu.EXMEMFlush = 1'b1;
        end else if (state == PCU_MDU_BUSY) begin
            // Final MDU cycle: result valid, everything advances.
            pcu.mduDone = 1'b1;
        end else begin
            // Single-cycle MDU completes in its issue cycle.
            pcu.mduDone = pcu.mduOp_EX & ~MDU_MULTI;
            if (pcu.redirect_EX) begin
                // Squashes the younger instructions, including a stalled one.
                pcu.IFIDFlush = 1'b1;
                pcu.IDEXFlush = 1'b1;
            end else if (pcu.loadUseStall_ID) begin
                pcu.PCEn      = 1'b0;
                pcu.IFIDEn    = 1'b0;
                pcu.IDEXFlush = 1'b1;
            end else begin
                pcu.PCEn = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Bench for pipeline_control_unit: two instances (MDU_LATENCY 4 and 1) see
// the same directed stimulus; a cycle-level model checks both every cycle
// and literal vectors pin the expected behaviour of the main scenarios.
module tb_pipeline_control_unit;

    // Output vector bit order:
    // [10]PCEn [9]IFIDEn [8]IDEXEn [7]EXMEMEn [6]MEMWBEn
    // [5]IFIDFlush [4]IDEXFlush [3]EXMEMFlush [2]MEMWBFlush [1]mduDone [0]memFault
    localparam logic [10:0] RUNV  = 11'b11111_0000_00;
    localparam logic [10:0] LUV   = 11'b00111_0100_00;
    localparam logic [10:0] MDUF  = 11'b00011_0010_00;
    localparam logic [10:0] DONEV = 11'b11111_0000_10;
    localparam logic [10:0] MEMS  = 11'b00001_0001_00;
    localparam logic [10:0] REDIR = 11'b11111_1100_00;
    localparam logic [10:0] HALTV = 11'b00000_0000_01;

`ifdef PIPE_MEM_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 64;
`endif

    logic clk = 1'b0;
    logic rstTb = 1'b1;
    logic luTb = 1'b0, rdTb = 1'b0, moTb = 1'b0, rqTb = 1'b0, rdyTb = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_control_unit_if if4 ();
    pipeline_control_unit_if if1 ();

    assign if4.loadUseStall_ID = luTb;
    assign if4.redirect_EX     = rdTb;
    assign if4.mduOp_EX        = moTb;
    assign if4.dmemReq_MEM     = rqTb;
    assign if4.dmemReady       = rdyTb;
    assign if1.loadUseStall_ID = luTb;
    assign if1.redirect_EX     = rdTb;
    assign if1.mduOp_EX        = moTb;
    assign if1.dmemReq_MEM     = rqTb;
    assign if1.dmemReady       = rdyTb;

    pipeline_control_unit #(.MDU_LATENCY(4), .MEM_TIMEOUT(TB_TIMEOUT), .CNT_WIDTH(8)) dut4 (
        .clk (clk), .rst (rstTb), .pcu (if4.slave)
    );
    pipeline_control_unit #(.MDU_LATENCY(1), .MEM_TIMEOUT(TB_TIMEOUT), .CNT_WIDTH(8)) dut1 (
        .clk (clk), .rst (rstTb), .pcu (if1.slave)
    );

    wire [10:0] out4 = {if4.PCEn, if4.IFIDEn, if4.IDEXEn, if4.EXMEMEn, if4.MEMWBEn,
                        if4.IFIDFlush, if4.IDEXFlush, if4.EXMEMFlush, if4.MEMWBFlush,
                        if4.mduDone, if4.memFault};
    wire [10:0] out1 = {if1.PCEn, if1.IFIDEn, if1.IDEXEn, if1.EXMEMEn, if1.MEMWBEn,
                        if1.IFIDFlush, if1.IDEXFlush, if1.EXMEMFlush, if1.MEMWBFlush,
                        if1.mduDone, if1.memFault};

    // Behavioural model: per instance, whether an MDU op is occupying EX and
    // how many cycles it has spent there, plus the stuck-memory bookkeeping.
    int  mLat[2]     = '{4, 1};
    bit  mBusy[2]    = '{1'b0, 1'b0};
    int  mElapsed[2] = '{0, 0};
    bit  mHalt[2]    = '{1'b0, 1'b0};
    int  mWait[2]    = '{0, 0};

    function automatic logic [10:0] modelOut(input int i);
        logic [10:0] v;
        bit mem;
        mem = rqTb & ~rdyTb;
        if (rstTb)    return RUNV;
        if (mHalt[i]) return HALTV;
        if (mem)      return MEMS;
        if (mBusy[i]) return (mElapsed[i] >= mLat[i] - 1) ? DONEV : MDUF;
        if (moTb && mLat[i] > 1) return MDUF;
        v = RUNV;
        if (moTb) v[1] = 1'b1;
        if (rdTb) begin
            v[5] = 1'b1;
            v[4] = 1'b1;
        end else if (luTb) begin
            v[10] = 1'b0;
            v[9]  = 1'b0;
            v[4]  = 1'b1;
        end
        return v;
    endfunction

    task automatic modelStep();
        bit mem;
        bit hNext;
        mem = rqTb & ~rdyTb;
        for (int i = 0; i < 2; i++) begin
            if (rstTb) begin
                mBusy[i] = 1'b0; mElapsed[i] = 0; mHalt[i] = 1'b0; mWait[i] = 0;
            end else if (!mHalt[i]) begin
                hNext = 1'b0;
`ifdef PIPE_MEM_TIMEOUT_EN
                if (mem) begin
                    if (mWait[i] == TB_TIMEOUT - 1) hNext = 1'b1;
                    mWait[i]++;
                end else begin
                    mWait[i] = 0;
                end
`endif
                if (mBusy[i]) begin
                    if (mElapsed[i] >= mLat[i] - 1 && !mem) mBusy[i] = 1'b0;
                    else mElapsed[i]++;
                end else if (moTb && mLat[i] > 1 && !mem) begin
                    mBusy[i] = 1'b1;
                    mElapsed[i] = 1;
                end
                mHalt[i] = hNext;
            end
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        logic [10:0] e;
        logic [10:0] g;
        if (!rstTb && !mBusy[0] && !mHalt[0] && rdTb && moTb) begin
            failures++;
            $display("FAIL illegal_stim t=%0t redirect and mduOp together in RUN", $time);
        end
        for (int i = 0; i < 2; i++) begin
            e = modelOut(i);
            g = (i == 0) ? out4 : out1;
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL model_cmp lat=%0d t=%0t got=%b expected=%b", mLat[i], $time, g, e);
            end
        end
        modelStep();
    end

    // Drive one cycle of inputs after the active edge and check literals
    // mid-cycle.
    task automatic step(input logic r, input logic lu, input logic rd, input logic mo,
                        input logic rq, input logic rdy,
                        input logic [10:0] exp4, input logic [10:0] exp1, input string name);
        @(posedge clk);
        #1;
        rstTb = r; luTb = lu; rdTb = rd; moTb = mo; rqTb = rq; rdyTb = rdy;
        @(negedge clk);
        #1;
        checks++;
        if (out4 !== exp4) begin
            failures++;
            $display("FAIL %s lat4 got=%b expected=%b", name, out4, exp4);
        end
        checks++;
        if (out1 !== exp1) begin
            failures++;
            $display("FAIL %s lat1 got=%b expected=%b", name, out1, exp1);
        end
    endtask

    initial begin
        step(1'b1, 0, 0, 0, 0, 0, RUNV, RUNV, "reset");
        step(1'b0, 0, 0, 0, 0, 0, RUNV, RUNV, "idle");
        // Load-use stall for one cycle.
        step(1'b0, 1, 0, 0, 0, 0, LUV, LUV, "loaduse");
        step(1'b0, 0, 0, 0, 0, 0, RUNV, RUNV, "loaduse_after");
        // MDU op held in EX: 3 freeze cycles then done for latency 4.
        for (int k = 0; k < 3; k++) step(1'b0, 0, 0, 1, 0, 0, MDUF, DONEV, "mdu_busy");
        step(1'b0, 0, 0, 1, 0, 0, DONEV, DONEV, "mdu_done");
        step(1'b0, 0, 0, 0, 0, 0, RUNV, RUNV, "mdu_after");
        // Memory wait with a pending redirect: redirect honoured on release.
        for (int k = 0; k < 5; k++) step(1'b0, 0, 1, 0, 1, 0, MEMS, MEMS, "memstall_redir");
        step(1'b0, 0, 1, 0, 1, 1, REDIR, REDIR, "mem_release_redir");
        step(1'b0, 0, 0, 0, 0, 0, RUNV, RUNV, "mem_after");
        // MDU issue followed by a 6-cycle memory wait: done held off, pulses once.
        step(1'b0, 0, 0, 1, 0, 0, MDUF, DONEV, "mdu_issue2");
        for (int k = 0; k < 6; k++) step(1'b0, 0, 0, 1, 1, 0, MEMS, MEMS, "mdu_memstall");
        step(1'b0, 0, 0, 1, 1, 1, DONEV, DONEV, "mdu_done_late");
        step(1'b0, 0, 0, 0, 0, 0, RUNV, RUNV, "mdu_done_once");
        // Redirect beats load-use.
        step(1'b0, 1, 1, 0, 0, 0, REDIR, REDIR, "redir_loaduse");
        step(1'b0, 0, 0, 0, 0, 0, RUNV, RUNV, "idle2");
        // Reset in the middle of an MDU op.
        step(1'b0, 0, 0, 1, 0, 0, MDUF, DONEV, "mdu_issue3");
        step(1'b0, 0, 0, 1, 0, 0, MDUF, DONEV, "mdu_busy3");
        step(1'b1, 0, 0, 1, 0, 0, RUNV, RUNV, "rst_mid_mdu");
        step(1'b0, 0, 0, 0, 0, 0, RUNV, RUNV, "after_rst_mdu");
`ifdef PIPE_MEM_TIMEOUT_EN
        // Stuck memory: 8 wait cycles, then HALT until reset.
        for (int k = 0; k < 8; k++) step(1'b0, 0, 0, 0, 1, 0, MEMS, MEMS, "timeout_wait");
        step(1'b0, 0, 0, 0, 1, 0, HALTV, HALTV, "halt");
        step(1'b0, 1, 1, 0, 0, 0, HALTV, HALTV, "halt_sticky");
        step(1'b1, 0, 0, 0, 0, 0, RUNV, RUNV, "halt_rst");
        step(1'b0, 0, 0, 0, 0, 0, RUNV, RUNV, "halt_exit");
`else
        // Without the timeout feature memory waits are unbounded.
        for (int k = 0; k < 70; k++) step(1'b0, 0, 0, 0, 1, 0, MEMS, MEMS, "long_wait");
        step(1'b0, 0, 0, 0, 1, 1, RUNV, RUNV, "long_wait_release");
`endif
        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
